fb_scanout_reader: RTL and testbench
====================================

// Module: fb_scanout_reader
// PURPOSE
// - Display-side reader of the 4-bit Julia framebuffer BRAM (port B). Generates 720p raster timing itself.
// - Issues sequential BRAM read addresses and expands each 4-bit pixel code to 8-bit RGB.
// - Outputs hsync, vsync and de, pipeline-aligned to the pixel data, toward the HDMI encoder.
// - Replaces the combinational addr = sx + sy*1280 path with an incrementing address counter.
// PARAMETERS
// H_RES    1280  active pixels per line
// V_RES    720   active lines per frame
// H_FP     110   horizontal front porch, in pixels
// H_SYNC   40    hsync width, in pixels
// H_BP     220   horizontal back porch, in pixels
// V_FP     5     vertical front porch, in lines
// V_SYNC   5     vsync width, in lines
// V_BP     20    vertical back porch, in lines
// RD_LAT   2     BRAM read latency in clk cycles (addrb to doutb), >=1
// ADDR_W   20    BRAM address width
// PORTS
// clk          in   1       pixel clock (74.25 MHz)
// rst          in   1       asynchronous reset, active-low
// en           in   1       scan-out enable, sampled only at frame boundary
// rd_en        out  1       BRAM port-B enable, high during active pixels
// rd_addr      out  ADDR_W  BRAM port-B address
// rd_data      in   4       BRAM port-B data, valid RD_LAT cycles after rd_addr
// o_red        out  8       red
// o_green      out  8       green
// o_blue       out  8       blue
// o_hsync      out  1       horizontal sync, active-high
// o_vsync      out  1       vertical sync, active-high
// o_de         out  1       data enable (active video)
// o_frame_start out 1       1-cycle pulse aligned with the first o_de of each frame
// BEHAVIOUR
// - Reset (rst=0) forces the following, asynchronously: all outputs 0, hcnt=vcnt=0, rd_addr=0, state=IDLE.
// - Frame geometry: line = H_RES+H_FP+H_SYNC+H_BP (1650) clocks; frame = V_RES+V_FP+V_SYNC+V_BP (750) lines.
// - Counters: hcnt runs 0..1649. At 1649, hcnt wraps to 0 and vcnt increments. At vcnt=749, vcnt wraps to 0.
// - Raster regions:
//   - active (raw de): hcnt<H_RES and vcnt<V_RES.
//   - hsync: H_RES+H_FP <= hcnt < H_RES+H_FP+H_SYNC.
//   - vsync: same form, applied to vcnt.
// - FSM states:
//   - IDLE: counters held at 0, all outputs 0, no reads issued. Moves to RUN when en=1.
//   - RUN: counters free-run. At the last clock of a frame (hcnt=1649, vcnt=749):
//     - en=0: move to IDLE.
//     - en=1: stay in RUN.
//   - en falling mid-frame never truncates a frame; the frame in progress always completes.
// - Addressing:
//   - rd_en = raw de.
//   - rd_addr holds its current value and increments by 1 after each active pixel.
//   - rd_addr resets to 0 at hcnt=0, vcnt=0.
//   - The last pixel of a frame uses address H_RES*V_RES-1 (921599). No multiplier is used.
// - Latency and alignment:
//   - raw de, hsync, vsync and frame_start go through an RD_LAT+1 stage delay line.
//   - rd_data is registered once. o_* therefore lag the raw timing by exactly RD_LAT+1 clocks.
// - Pixel expansion (default build): o_red = o_green = o_blue = {rd_data, rd_data}, i.e. code*17, 0..255 gray.
// - Blanking: o_red, o_green and o_blue are 0 whenever o_de=0, regardless of rd_data.
// - Writer independence: concurrent port-A writes are not arbitrated. A pixel rewritten in the same cycle it is read shows old or new data.
// CONFIGURATION
// - Macro FB_PSEUDOCOLOR_EN.
// - Defined: o_red = d*17; o_green = (15-d)*17; o_blue = d[3] ? 8'hFF : 8'h00.
// - Defined: latency, timing and blanking are unchanged.
// - Undefined: gray expansion as above; no palette logic synthesized.
// TESTING
// - Reset, then en=1 with RD_LAT=2 -> first o_de=1 and o_frame_start=1 at clock 3 after leaving IDLE.
//   Output pixel = BRAM[0].
// - BRAM model with code = addr[3:0]:
//   - pixel 1279 of line 0 -> 8'hFF gray.
//   - pixel 0 of line 1 reads addr 1280 -> 8'h00.
// - Count over one frame:
//   - o_hsync high for 40 clocks per line, starting 1390 clocks after line start.
//   - o_vsync high for 5 lines.
//   - 921600 o_de cycles.
// - Drop en at vcnt=300 -> frame completes to vcnt=749, then IDLE: all outputs 0, rd_en=0.
//   Reassert en -> new frame starts at rd_addr=0.
// - Assert rst low mid-line (hcnt=500) -> all outputs 0 immediately, without waiting for clk.
//   Release with en=1 -> timing restarts from hcnt=0, vcnt=0.
// - FB_PSEUDOCOLOR_EN build, code 4'd3 -> RGB = (51, 204, 0).
//   Code 4'd12 -> RGB = (204, 51, 255). Blanking region -> (0, 0, 0).

Source files
------------

// File: rtl/fb_scanout_reader.sv
// 720p scan-out reader for the 4-bit framebuffer: raster timing, sequential BRAM addressing and
// pixel expansion. Define FB_PSEUDOCOLOR_EN to replace the gray ramp with a pseudocolor palette.
module fb_scanout_reader #(
  parameter int H_RES  = 1280,
  parameter int V_RES  = 720,
  parameter int H_FP   = 110,
  parameter int H_SYNC = 40,
  parameter int H_BP   = 220,
  parameter int V_FP   = 5,
  parameter int V_SYNC = 5,
  parameter int V_BP   = 20,
  parameter int RD_LAT = 2,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [3:0]        rd_data,
  output logic [7:0]        o_red,
  output logic [7:0]        o_green,
  output logic [7:0]        o_blue,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic              o_de,
  output logic              o_frame_start
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_RES);
  localparam logic [HW-1:0] HS_BEG = HW'(H_RES + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_RES + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_RES);
  localparam logic [VW-1:0] VS_BEG = VW'(V_RES + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_RES + V_FP + V_SYNC);

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
    logic frame_start;
  } timing_t;

  state_t            state_q, state_d;
  logic [HW-1:0]     hcnt;
  logic [VW-1:0]     vcnt;
  logic [ADDR_W-1:0] addr_q;
  logic              frame_last;
  timing_t           raw;
  timing_t [RD_LAT:0] dl;
  logic [3:0]        pix_q;
  logic [7:0]        red_c, green_c, blue_c;

  assign frame_last = (state_q == RUN) && (hcnt == H_LAST) && (vcnt == V_LAST);

  // en only matters on the last clock of a frame, so a frame in progress always completes.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a missed branch would infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (frame_last && !en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    raw = '0;
    if (state_q == RUN) begin
      raw.de          = (hcnt < H_ACT) && (vcnt < V_ACT);
      raw.hsync       = (hcnt >= HS_BEG) && (hcnt < HS_END);
      raw.vsync       = (vcnt >= VS_BEG) && (vcnt < VS_END);
      raw.frame_start = (hcnt == '0) && (vcnt == '0);
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      hcnt    <= '0;
      vcnt    <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q != RUN) begin
        hcnt   <= '0;
        vcnt   <= '0;
        addr_q <= '0;
      end else begin
        if (hcnt == H_LAST) begin
          hcnt <= '0;
          vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end else begin
          hcnt <= hcnt + 1'b1;
        end
        // Running address replaces sx + sy*H_RES; it rewinds exactly where the raster wraps.
        if (frame_last)  addr_q <= '0;
        else if (raw.de) addr_q <= addr_q + 1'b1;
      end
    end
  end

  // Timing flags travel RD_LAT+1 stages: RD_LAT for the BRAM plus one for the pixel register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the delay line and pixel register take the async reset because they drive the
    // sync and colour pins directly; a plain data pipeline would not need it.
    if (!rst) begin
      dl    <= '0;
      pix_q <= '0;
    end else begin
      dl    <= {dl[RD_LAT-1:0], raw};
      pix_q <= rd_data;
    end
  end

`ifdef FB_PSEUDOCOLOR_EN
  always_comb begin
    red_c   = {pix_q, pix_q};
    green_c = {~pix_q, ~pix_q};
    blue_c  = {8{pix_q[3]}};
  end
`else
  assign red_c   = {pix_q, pix_q};
  assign green_c = red_c;
  assign blue_c  = red_c;
`endif

  assign rd_en         = raw.de;
  assign rd_addr       = addr_q;
  assign o_de          = dl[RD_LAT].de;
  assign o_hsync       = dl[RD_LAT].hsync;
  assign o_vsync       = dl[RD_LAT].vsync;
  assign o_frame_start = dl[RD_LAT].frame_start;
  assign o_red         = o_de ? red_c   : 8'h00;
  assign o_green       = o_de ? green_c : 8'h00;
  assign o_blue        = o_de ? blue_c  : 8'h00;

endmodule

// File: tb/tb_fb_scanout_reader.sv
// Self-checking bench for fb_scanout_reader on a shrunken raster; outputs are predicted from
// the raster position of each run cycle and a behavioural BRAM image.
module tb_fb_scanout_reader;

  localparam int H_RES  = 16;
  localparam int H_FP   = 3;
  localparam int H_SYNC = 4;
  localparam int H_BP   = 5;
  localparam int V_RES  = 6;
  localparam int V_FP   = 2;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 3;
  localparam int RD_LAT = 2;
  localparam int ADDR_W = 20;
  localparam int HT     = H_RES + H_FP + H_SYNC + H_BP;
  localparam int VT     = V_RES + V_FP + V_SYNC + V_BP;
  localparam int FRAME  = HT * VT;
  localparam int DLY    = RD_LAT + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              en  = 1'b0;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [3:0]        rd_data;
  logic [7:0]        o_red, o_green, o_blue;
  logic              o_hsync, o_vsync, o_de, o_frame_start;

  logic [3:0] mem [128];
  logic [3:0] bp1 = 4'h0;
  logic [3:0] bp2 = 4'h0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         tr    = 0;   // raw raster cycle index since the current run left IDLE

  fb_scanout_reader #(
    .H_RES(H_RES), .V_RES(V_RES), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .RD_LAT(RD_LAT), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .o_red(o_red), .o_green(o_green), .o_blue(o_blue), .o_hsync(o_hsync),
    .o_vsync(o_vsync), .o_de(o_de), .o_frame_start(o_frame_start)
  );

  always #5 clk = ~clk;

  // Two-cycle BRAM port B
  always @(posedge clk) begin
    bp1 <= mem[rd_addr[6:0]];
    bp2 <= bp1;
  end
  assign rd_data = bp2;

  function automatic logic [23:0] expand(input logic [3:0] d);
    int c;
    c = int'(d);
`ifdef FB_PSEUDOCOLOR_EN
    return {8'(c * 17), 8'((15 - c) * 17), (c >= 8) ? 8'd255 : 8'd0};
`else
    return {3{8'(c * 17)}};
`endif
  endfunction

  // Expected {de, hsync, vsync, frame_start, rgb} for raw cycle r of a run; r < 0 is idle.
  function automatic logic [27:0] exp_out(input int r);
    int n, h, v;
    logic de, hs, vs, fs;
    logic [23:0] rgb;
    if (r < 0) return '0;
    n  = r % FRAME;
    h  = n % HT;
    v  = n / HT;
    de = (h < H_RES) && (v < V_RES);
    hs = (h >= H_RES + H_FP) && (h < H_RES + H_FP + H_SYNC);
    vs = (v >= V_RES + V_FP) && (v < V_RES + V_FP + V_SYNC);
    fs = (n == 0);
    rgb = 24'h0;
    if (de) rgb = expand(mem[v * H_RES + h]);
    return {de, hs, vs, fs, rgb};
  endfunction

  // Expected {rd_en, rd_addr}: the address is the count of active pixels already read this frame.
  function automatic logic [ADDR_W:0] exp_rd(input int r);
    int n, h, v, a;
    logic de;
    if (r < 0) return '0;
    n  = r % FRAME;
    h  = n % HT;
    v  = n / HT;
    de = (h < H_RES) && (v < V_RES);
    if (v >= V_RES) a = H_RES * V_RES;
    else            a = v * H_RES + ((h < H_RES) ? h : H_RES);
    return {de, ADDR_W'(a)};
  endfunction

  function automatic logic [27:0] obs_out();
    return {o_de, o_hsync, o_vsync, o_frame_start, o_red, o_green, o_blue};
  endfunction

  function automatic logic [ADDR_W:0] obs_rd();
    return {rd_en, rd_addr};
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    en  = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({obs_out(), obs_rd()} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got %h/%h expected all zero", obs_out(), obs_rd());
    end
    rst = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if ({obs_out(), obs_rd()} !== '0) begin
      n_bad++;
      $display("FAIL idle_en_low: got %h/%h expected all zero", obs_out(), obs_rd());
    end
  endtask

  task automatic test_first_frame();
    logic [27:0]       got, want;
    logic [ADDR_W:0]   rgot, rwant;
    logic [23:0]       rgb;
    int n_de = 0, n_hs = 0, n_vs = 0, hs_first = -1;
    for (int a = 0; a < 128; a++) mem[a] = 4'(a);
    en = 1'b1;
    @(posedge clk);
    for (int k = 0; k < FRAME + DLY; k++) begin
      @(negedge clk);
      got  = obs_out();
      want = exp_out(k - DLY);
      rgot = obs_rd();
      rwant = exp_rd(k);
      rgb  = {o_red, o_green, o_blue};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL first_frame_out k=%0d: got %h expected %h", k, got, want);
      end
      n_cmp++;
      if (rgot !== rwant) begin
        n_bad++;
        $display("FAIL first_frame_rd k=%0d: got %h expected %h", k, rgot, rwant);
      end
      if (k == DLY - 1) begin
        n_cmp++;
        if (o_de !== 1'b0) begin
          n_bad++;
          $display("FAIL de_too_early: got %b expected 0", o_de);
        end
      end
      if (k == DLY) begin
        n_cmp++;
        if ({o_de, o_frame_start, rgb} !== {2'b11, expand(mem[0])}) begin
          n_bad++;
          $display("FAIL first_pixel: got %b%b %h expected 11 %h", o_de, o_frame_start, rgb,
                   expand(mem[0]));
        end
      end
      if (k - DLY == 3) begin
        n_cmp++;
`ifdef FB_PSEUDOCOLOR_EN
        if (rgb !== 24'h33CC00) begin
          n_bad++;
          $display("FAIL code3_rgb: got %h expected 33cc00", rgb);
        end
`else
        if (rgb !== 24'h333333) begin
          n_bad++;
          $display("FAIL code3_rgb: got %h expected 333333", rgb);
        end
`endif
      end
      if (k - DLY == 12) begin
        n_cmp++;
`ifdef FB_PSEUDOCOLOR_EN
        if (rgb !== 24'hCC33FF) begin
          n_bad++;
          $display("FAIL code12_rgb: got %h expected cc33ff", rgb);
        end
`else
        if (rgb !== 24'hCCCCCC) begin
          n_bad++;
          $display("FAIL code12_rgb: got %h expected cccccc", rgb);
        end
`endif
      end
      if (k - DLY == H_RES - 1) begin
        n_cmp++;
        if (o_red !== 8'hFF) begin
          n_bad++;
          $display("FAIL line0_last_pixel: got %h expected ff", o_red);
        end
      end
      if (k == HT) begin
        n_cmp++;
        if (rd_addr !== ADDR_W'(H_RES)) begin
          n_bad++;
          $display("FAIL line1_addr: got %0d expected %0d", rd_addr, H_RES);
        end
      end
      if (k - DLY == HT) begin
        n_cmp++;
        if (o_red !== 8'h00) begin
          n_bad++;
          $display("FAIL line1_first_pixel: got %h expected 00", o_red);
        end
      end
      if (k >= DLY) begin
        n_de += int'(o_de);
        n_hs += int'(o_hsync);
        n_vs += int'(o_vsync);
        if (o_hsync && hs_first < 0) hs_first = k - DLY;
      end
    end
    tr = FRAME + DLY;
    n_cmp++;
    if (n_de != H_RES * V_RES) begin
      n_bad++;
      $display("FAIL de_count: got %0d expected %0d", n_de, H_RES * V_RES);
    end
    n_cmp++;
    if (n_hs != H_SYNC * VT) begin
      n_bad++;
      $display("FAIL hsync_count: got %0d expected %0d", n_hs, H_SYNC * VT);
    end
    n_cmp++;
    if (hs_first != H_RES + H_FP) begin
      n_bad++;
      $display("FAIL hsync_start: got %0d expected %0d", hs_first, H_RES + H_FP);
    end
    n_cmp++;
    if (n_vs != V_SYNC * HT) begin
      n_bad++;
      $display("FAIL vsync_count: got %0d expected %0d", n_vs, V_SYNC * HT);
    end
  endtask

  // Continuous frames with a fresh random image each vblank and en toggling randomly mid-frame.
  task automatic test_back_to_back();
    logic [27:0]     want;
    logic [ADDR_W:0] rwant;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      want  = exp_out(tr - DLY);
      rwant = exp_rd(tr);
      n_cmp++;
      if (obs_out() !== want) begin
        n_bad++;
        $display("FAIL b2b_out tr=%0d: got %h expected %h", tr, obs_out(), want);
      end
      n_cmp++;
      if (obs_rd() !== rwant) begin
        n_bad++;
        $display("FAIL b2b_rd tr=%0d: got %h expected %h", tr, obs_rd(), rwant);
      end
      if (tr % FRAME == V_RES * HT + DLY)
        for (int a = 0; a < 128; a++) mem[a] = 4'($urandom);
      en = (tr % FRAME == FRAME - 1) ? 1'b1 : 1'($urandom);
      tr++;
    end
    en = 1'b1;
  endtask

  task automatic test_en_drop();
    logic [27:0]     want;
    logic [ADDR_W:0] rwant;
    int              fend;
    fend = tr - (tr % FRAME) + FRAME;
    en   = 1'b1;
    while (tr < fend + 2 * HT) begin
      @(negedge clk);
      want  = exp_out((tr - DLY < fend) ? tr - DLY : -1);
      rwant = exp_rd((tr < fend) ? tr : -1);
      n_cmp++;
      if (obs_out() !== want) begin
        n_bad++;
        $display("FAIL en_drop_out tr=%0d: got %h expected %h", tr, obs_out(), want);
      end
      n_cmp++;
      if (obs_rd() !== rwant) begin
        n_bad++;
        $display("FAIL en_drop_rd tr=%0d: got %h expected %h", tr, obs_rd(), rwant);
      end
      if (tr % FRAME == 3 * HT + 5 && tr < fend) en = 1'b0;
      tr++;
    end
    n_cmp++;
    if ({obs_out(), obs_rd()} !== '0) begin
      n_bad++;
      $display("FAIL idle_after_drop: got %h/%h expected all zero", obs_out(), obs_rd());
    end
    for (int a = 0; a < 128; a++) mem[a] = 4'($urandom);
    repeat ($urandom_range(1, 20)) @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    tr = 0;
    for (int i = 0; i < FRAME + DLY; i++) begin
      @(negedge clk);
      want  = exp_out(tr - DLY);
      rwant = exp_rd(tr);
      if (tr == 0) begin
        n_cmp++;
        if (obs_rd() !== {1'b1, {ADDR_W{1'b0}}}) begin
          n_bad++;
          $display("FAIL restart_addr: got %h expected rd_en=1 addr=0", obs_rd());
        end
      end
      n_cmp++;
      if (obs_out() !== want) begin
        n_bad++;
        $display("FAIL restart_out tr=%0d: got %h expected %h", tr, obs_out(), want);
      end
      n_cmp++;
      if (obs_rd() !== rwant) begin
        n_bad++;
        $display("FAIL restart_rd tr=%0d: got %h expected %h", tr, obs_rd(), rwant);
      end
      tr++;
    end
  endtask

  task automatic test_async_reset();
    logic [27:0]     want;
    logic [ADDR_W:0] rwant;
    bit              hit = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      want = exp_out(tr - DLY);
      n_cmp++;
      if (obs_out() !== want) begin
        n_bad++;
        $display("FAIL pre_reset_out tr=%0d: got %h expected %h", tr, obs_out(), want);
      end
      if (tr % FRAME == HT + 10) begin
        hit = 1'b1;
        break;
      end
      tr++;
    end
    n_cmp++;
    if (!hit || o_de !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_active: got hit=%b de=%b expected 1/1", hit, o_de);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({obs_out(), obs_rd()} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got %h/%h expected all zero", obs_out(), obs_rd());
    end
    repeat (2) @(negedge clk);
    en  = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    tr = 0;
    for (int i = 0; i < 2 * HT + DLY; i++) begin
      @(negedge clk);
      want  = exp_out(tr - DLY);
      rwant = exp_rd(tr);
      n_cmp++;
      if (obs_out() !== want) begin
        n_bad++;
        $display("FAIL post_reset_out tr=%0d: got %h expected %h", tr, obs_out(), want);
      end
      n_cmp++;
      if (obs_rd() !== rwant) begin
        n_bad++;
        $display("FAIL post_reset_rd tr=%0d: got %h expected %h", tr, obs_rd(), rwant);
      end
      tr++;
    end
  endtask

  initial begin
    for (int a = 0; a < 128; a++) mem[a] = 4'h0;
    test_reset();
    test_first_frame();
    test_back_to_back();
    test_en_drop();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
